id_remap_alloc_ctrl: RTL

Allocation and bookkeeping controller for an AXI ID remapper, for one direction (AW/B or AR/R); instantiate one per direction. It maps wide slave-port IDs onto a small pool of master-port IDs (table indices) and counts in-flight transactions per mapping. It frees a mapping when its last response returns. It also provides a drain sequencer that blocks new allocations until all mappings retire, so the ID width converter can be quiesced safely.

---
 rtl/id_remap_alloc_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/id_remap_alloc_ctrl.sv
// ID allocation and in-flight bookkeeping for one direction of an AXI ID remapper,
// with a drain sequencer that blocks new allocations until every mapping retires.
module id_remap_alloc_ctrl #(
  parameter int SlvIdWidth   = 4,
  parameter int NumEntries   = 4,
  parameter int MaxTxnsPerId = 4,
  localparam int MstIdWidth  = (NumEntries > 1) ? $clog2(NumEntries) : 1,
  localparam int CntW        = $clog2(MaxTxnsPerId + 1),
  localparam int FreeW       = $clog2(NumEntries + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [SlvIdWidth-1:0] push_slv_id_i,
  output logic [MstIdWidth-1:0] push_mst_id_o,
  input  logic                  pop_valid_i,
  input  logic [MstIdWidth-1:0] pop_mst_id_i,
  output logic [SlvIdWidth-1:0] pop_slv_id_o,
  input  logic                  drain_req_i,
  output logic                  drain_done_o,
  output logic                  busy_o,
  output logic [FreeW-1:0]      free_cnt_o,
  output logic                  err_o
);

  if (NumEntries < 1) begin : g_chk_entries
    $error("NumEntries must be at least 1");
  end
  if (NumEntries > 2 ** MstIdWidth) begin : g_chk_width
    $error("NumEntries exceeds master ID range");
  end
  if (MaxTxnsPerId < 1) begin : g_chk_max
    $error("MaxTxnsPerId must be at least 1");
  end
  if (SlvIdWidth < 1) begin : g_chk_slv
    $error("SlvIdWidth must be at least 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [SlvIdWidth-1:0] slv_id_q [NumEntries];
  logic [SlvIdWidth-1:0] slv_id_d [NumEntries];
  logic [CntW-1:0]       cnt_q    [NumEntries];
  logic [CntW-1:0]       cnt_d    [NumEntries];
  logic                  err_q;

  logic                  hit, free_found, push_fire;
  logic [MstIdWidth-1:0] hit_idx, free_idx;
  logic [CntW-1:0]       hit_cnt, pop_cnt;
  logic                  pop_in_range, pop_ok, pop_err;

  // Lookup uses only pre-update state, so a slot freed by a same-cycle pop is not reused.
  always_comb begin
    hit          = 1'b0;
    hit_idx      = '0;
    hit_cnt      = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    pop_in_range = 1'b0;
    pop_cnt      = '0;
    pop_slv_id_o = '0;
    for (int i = 0; i < NumEntries; i++) begin
      if (cnt_q[i] != '0 && slv_id_q[i] == push_slv_id_i) begin
        hit     = 1'b1;
        hit_idx = MstIdWidth'(i);
        hit_cnt = cnt_q[i];
      end
      if (pop_mst_id_i == MstIdWidth'(i)) begin
        pop_in_range = 1'b1;
        pop_cnt      = cnt_q[i];
        pop_slv_id_o = slv_id_q[i];
      end
    end
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (cnt_q[i] == '0) begin
        free_found = 1'b1;
        free_idx   = MstIdWidth'(i);
      end
    end
  end

  assign push_mst_id_o = hit ? hit_idx : free_idx;
  assign push_ready_o  = push_valid_i && (state_q == ST_IDLE) &&
                         (hit ? (hit_cnt < CntW'(MaxTxnsPerId)) : free_found);
  assign push_fire     = push_ready_o;
  assign pop_ok        = pop_valid_i && pop_in_range && (pop_cnt != '0);
  assign pop_err       = pop_valid_i && !pop_ok;

  always_comb begin
    for (int i = 0; i < NumEntries; i++) begin
      cnt_d[i]    = cnt_q[i];
      slv_id_d[i] = slv_id_q[i];
      if (push_fire && push_mst_id_o == MstIdWidth'(i) &&
          !(pop_ok && pop_mst_id_i == MstIdWidth'(i))) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end else if (pop_ok && pop_mst_id_i == MstIdWidth'(i) &&
                   !(push_fire && push_mst_id_o == MstIdWidth'(i))) begin
        cnt_d[i] = cnt_q[i] - CntW'(1);
      end
      if (push_fire && !hit && push_mst_id_o == MstIdWidth'(i)) begin
        slv_id_d[i] = push_slv_id_i;
      end
    end
  end

  always_comb begin
    busy_o     = 1'b0;
    free_cnt_o = '0;
    for (int i = 0; i < NumEntries; i++) begin
      if (cnt_q[i] != '0) busy_o = 1'b1;
      else                free_cnt_o = free_cnt_o + FreeW'(1);
    end
  end

  // Drain completion looks at registered counts, so DONE lags the last retire by a cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (drain_req_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req_i) state_d = ST_IDLE;
        else if (!busy_o) state_d = ST_DONE;
      end
      ST_DONE:  if (!drain_req_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign drain_done_o = (state_q == ST_DONE);
  assign err_o        = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      for (int i = 0; i < NumEntries; i++) begin
        cnt_q[i]    <= '0;
        slv_id_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      err_q   <= pop_err;
      for (int i = 0; i < NumEntries; i++) begin
        cnt_q[i]    <= cnt_d[i];
        slv_id_q[i] <= slv_id_d[i];
      end
    end
  end

endmodule
